// File: rtl/spi_wrapper_pkg.sv
// -----------------------------------------------------------------------------
// spi_wrapper_pkg
// Shared definitions for the SPI slave + single-port RAM wrapper:
//   - slave FSM state encoding (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA)
//   - frame command codes carried in frame bits [9:8]
// No ports; imported by spi_slave, sp_sync_ram and the bench.
// -----------------------------------------------------------------------------
package spi_wrapper_pkg;

    // Slave FSM states
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    // Frame command codes
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_wrapper_ram.sv
// -----------------------------------------------------------------------------
// sp_sync_ram
// Single-port synchronous RAM driven by received SPI frames. Acts only on
// cycles with rx_valid, decoding din[9:8] as write-address, write-data,
// read-address or read-data; read data is returned on dout with tx_valid.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears all words)
//   SS_n              slave select; high drops tx_valid
//   rx_valid, din     received frame and its strobe
//   dout, tx_valid    read data and its level-valid flag
// -----------------------------------------------------------------------------
module sp_sync_ram
    import spi_wrapper_pkg::*;
#(
    parameter int MEM_DEPTH      = 256,
    parameter int DATA_ADDR_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SS_n,
    input  logic                      rx_valid,
    input  logic [DATA_ADDR_SIZE+1:0] din,
    output logic [DATA_ADDR_SIZE-1:0] dout,
    output logic                      tx_valid
);

    logic [DATA_ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [DATA_ADDR_SIZE-1:0] wr_addr;
    logic [DATA_ADDR_SIZE-1:0] rd_addr;
    logic [1:0]                cmd;
    logic [DATA_ADDR_SIZE-1:0] payload;

    always_comb begin
        cmd     = din[DATA_ADDR_SIZE+1:DATA_ADDR_SIZE];
        payload = din[DATA_ADDR_SIZE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= '0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else begin
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr  <= payload;
                        tx_valid <= 1'b0;
                    end
                    CMD_WR_DATA: begin
                        mem[wr_addr] <= payload;
                        tx_valid     <= 1'b0;
                    end
                    CMD_RD_ADDR: begin
                        rd_addr  <= payload;
                        tx_valid <= 1'b0;
                    end
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                endcase
            end
            // End of transaction always withdraws the read data.
            if (SS_n)
                tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_wrapper_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Receives 10-bit frames (cmd[1:0] + payload) MSB first on MOSI while SS_n is
// low, presents each completed frame on rx_data with a one-cycle rx_valid, and
// in READ_DATA serializes the RAM's dout on MISO once tx_valid arrives.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   SS_n, MOSI        slave select (active-low), serial data in
//   tx_valid, dout    read data handed back by the RAM
//   MISO              serial data out, 0 when idle
//   rx_data, rx_valid received frame and its one-cycle strobe
// -----------------------------------------------------------------------------
module spi_slave
    import spi_wrapper_pkg::*;
#(
    parameter int DATA_ADDR_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SS_n,
    input  logic                      MOSI,
    input  logic                      tx_valid,
    input  logic [DATA_ADDR_SIZE-1:0] dout,
    output logic                      MISO,
    output logic [DATA_ADDR_SIZE+1:0] rx_data,
    output logic                      rx_valid
);

    localparam int FRAME_W = DATA_ADDR_SIZE + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int IDX_W   = $clog2(DATA_ADDR_SIZE);

    // bit_count == CNT_FULL: last frame bit just sampled.
    // bit_count == CNT_DONE: frame handed off, waiting for SS_n to rise.
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(FRAME_W + 1);
    localparam logic [IDX_W-1:0] IDX_START = IDX_W'(DATA_ADDR_SIZE - 2);

    localparam logic [1:0] TX_WAIT  = 2'd0;
    localparam logic [1:0] TX_SHIFT = 2'd1;
    localparam logic [1:0] TX_END   = 2'd2;

    logic [2:0]                cs;
    logic [2:0]                ns;
    logic [CNT_W-1:0]          bit_count;
    logic [FRAME_W-1:0]        shreg;
    logic [DATA_ADDR_SIZE-1:0] tx_data;
    logic                      rd_addr_Done;
    logic [1:0]                tx_phase;
    logic [IDX_W-1:0]          tx_idx;
    logic                      in_frame;
    logic                      shift_en;

    always_comb begin
        in_frame = (cs == WRITE) || (cs == READ_ADD) || (cs == READ_DATA);
        shift_en = !SS_n && ((cs == CHK_CMD) || (in_frame && (bit_count < CNT_FULL)));
    end

    always_comb begin
        ns = cs;
        if (SS_n) begin
            ns = IDLE;
        end else begin
            case (cs)
                IDLE:                         ns = CHK_CMD;
                // Frame bit 9 picks the branch; a read goes to READ_DATA only
                // once an address frame has been accepted.
                CHK_CMD:                      ns = !MOSI ? WRITE
                                                   : (rd_addr_Done ? READ_DATA : READ_ADD);
                WRITE, READ_ADD, READ_DATA:   ns = cs;
                default:                      ns = IDLE;
            endcase
        end
    end

    // Shift register needs no reset: a frame is only consumed after all of its
    // bits have been shifted in.
    always_ff @(posedge clk) begin
        if (shift_en)
            shreg <= {shreg[FRAME_W-2:0], MOSI};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs           <= IDLE;
            bit_count    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_data      <= '0;
            rd_addr_Done <= 1'b0;
            MISO         <= 1'b0;
            tx_phase     <= TX_WAIT;
            tx_idx       <= '0;
        end else begin
            cs       <= ns;
            rx_valid <= 1'b0;
            MISO     <= 1'b0;
            if (SS_n || (cs == IDLE)) begin
                // Abort: counters cleared, rd_addr_Done deliberately untouched.
                bit_count <= '0;
                tx_phase  <= TX_WAIT;
                tx_idx    <= '0;
            end else if (cs == CHK_CMD) begin
                bit_count <= CNT_W'(1);
            end else if (in_frame) begin
                if (bit_count < CNT_FULL) begin
                    bit_count <= bit_count + 1'b1;
                end else if (bit_count == CNT_FULL) begin
                    rx_data   <= shreg;
                    rx_valid  <= 1'b1;
                    bit_count <= CNT_DONE;
                    if (cs == READ_ADD)
                        rd_addr_Done <= 1'b1;
                end else if (cs == READ_DATA) begin
                    case (tx_phase)
                        // MSB goes out on the same edge the byte is captured.
                        TX_WAIT: begin
                            if (tx_valid) begin
                                tx_data  <= dout;
                                MISO     <= dout[DATA_ADDR_SIZE-1];
                                tx_idx   <= IDX_START;
                                tx_phase <= TX_SHIFT;
                            end
                        end
                        TX_SHIFT: begin
                            MISO <= tx_data[tx_idx];
                            if (tx_idx == '0) begin
                                tx_phase     <= TX_END;
                                rd_addr_Done <= 1'b0;
                            end else begin
                                tx_idx <= tx_idx - 1'b1;
                            end
                        end
                        default: tx_phase <= tx_phase;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/spi_wrapper.sv
// -----------------------------------------------------------------------------
// spi_wrapper
// SPI slave front-end (spi_slave) feeding a single-port RAM (sp_sync_ram).
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   SS_n   slave select, active-low
//   MOSI   serial data in, MSB first
//   MISO   serial data out, MSB first, 0 when not transmitting
// -----------------------------------------------------------------------------
module spi_wrapper #(
    parameter int MEM_DEPTH      = 256,
    parameter int DATA_ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    logic [DATA_ADDR_SIZE+1:0] rx_data;
    logic                      rx_valid;
    logic [DATA_ADDR_SIZE-1:0] dout;
    logic                      tx_valid;

    spi_slave #(
        .DATA_ADDR_SIZE (DATA_ADDR_SIZE)
    ) spi_slave_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_valid (tx_valid),
        .dout     (dout),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    sp_sync_ram #(
        .MEM_DEPTH      (MEM_DEPTH),
        .DATA_ADDR_SIZE (DATA_ADDR_SIZE)
    ) ram_inst (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .rx_valid (rx_valid),
        .din      (rx_data),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

endmodule

// File: tb/tb_spi_wrapper.sv
// -----------------------------------------------------------------------------
// tb_spi_wrapper
// Table of frames with hand-derived expected results, a queue of expected
// MISO bytes, and hand-written abort / mid-frame reset sequences.
// -----------------------------------------------------------------------------
module tb_spi_wrapper;
    import spi_wrapper_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n  = 1'b1;
    logic MOSI  = 1'b0;
    logic MISO;

    int passed = 0;
    int total  = 0;

    logic [7:0] sb_q[$];

    typedef struct {
        logic [9:0] frame;
        logic [7:0] addr;
        logic [7:0] val;
        logic       done;
    } vec_t;

    vec_t vecs[15];

    spi_wrapper #(
        .MEM_DEPTH      (256),
        .DATA_ADDR_SIZE (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic reset_checks(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++)
            if (dut.ram_inst.mem[i] !== 8'h00) nz++;
        chk({tag, "_mem_nonzero_words"}, nz, 0);
        chk({tag, "_dout"}, dut.ram_inst.dout, 0);
        chk({tag, "_tx_valid"}, dut.ram_inst.tx_valid, 0);
        chk({tag, "_wr_addr"}, dut.ram_inst.wr_addr, 0);
        chk({tag, "_rd_addr"}, dut.ram_inst.rd_addr, 0);
        chk({tag, "_rx_data"}, dut.spi_slave_inst.rx_data, 0);
        chk({tag, "_rx_valid"}, dut.spi_slave_inst.rx_valid, 0);
        chk({tag, "_miso"}, MISO, 0);
        chk({tag, "_cs"}, dut.spi_slave_inst.cs, IDLE);
        chk({tag, "_rd_addr_done"}, dut.spi_slave_inst.rd_addr_Done, 0);
    endtask

    // One complete transaction: SS_n low, 10 frame bits, hold, SS_n high.
    task automatic run_frame(input logic [9:0] fr);
        int         hold;
        int         rxv;
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       rd;
        rd   = (fr[9:8] == CMD_RD_DATA);
        hold = rd ? 14 : 3;
        rxv  = 0;
        got  = '0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            MOSI = fr[i];
        end
        // k-th negedge below follows edge N+k-1 (N = edge sampling bit 0)
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (dut.spi_slave_inst.rx_valid) rxv++;
            if (k == 2) chk("rx_data_frame", dut.spi_slave_inst.rx_data, fr);
            if (rd && k == 3) chk("tx_valid_rise", dut.ram_inst.tx_valid, 1);
            if (rd && k >= 4 && k <= 11) got = {got[6:0], MISO};
            if (rd && k == 12) chk("miso_zero_after_byte", MISO, 0);
        end
        chk("rx_valid_pulses", rxv, 1);
        if (rd) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL miso_byte: got 0x%0h expected <scoreboard empty>", got);
            end else begin
                exp_b = sb_q.pop_front();
                chk("miso_byte", got, exp_b);
            end
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        chk("fsm_idle_after_ss", dut.spi_slave_inst.cs, IDLE);
        if (rd) chk("tx_valid_drop", dut.ram_inst.tx_valid, 0);
    endtask

    // Drives SS_n low plus the top nbits of fr, then raises SS_n.
    task automatic abort_frame(input logic [9:0] fr, input int nbits,
                               input logic [2:0] exp_state, output int rxv);
        rxv = 0;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            MOSI = fr[i];
            if (dut.spi_slave_inst.rx_valid) rxv++;
        end
        @(negedge clk);
        chk("state_before_abort", dut.spi_slave_inst.cs, exp_state);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        chk("abort_idle", dut.spi_slave_inst.cs, IDLE);
        chk("abort_bit_count", dut.spi_slave_inst.bit_count, 0);
        for (int i = 0; i < 3; i++) begin
            if (dut.spi_slave_inst.rx_valid) rxv++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         rxv;
        logic [9:0] fr;

        vecs[0]  = '{10'b00_0111_0011, 8'h00, 8'h73, 1'b0};
        vecs[1]  = '{10'b01_0000_1101, 8'h73, 8'h0D, 1'b0};
        vecs[2]  = '{10'b10_0111_0011, 8'h00, 8'h73, 1'b1};
        vecs[3]  = '{10'b11_0000_0000, 8'h00, 8'h0D, 1'b0};
        vecs[4]  = '{10'b00_1111_1111, 8'h00, 8'hFF, 1'b0};
        vecs[5]  = '{10'b01_1111_1111, 8'hFF, 8'hFF, 1'b0};
        vecs[6]  = '{10'b00_0000_0000, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{10'b01_1010_0101, 8'h00, 8'hA5, 1'b0};
        vecs[8]  = '{10'b10_1111_1111, 8'h00, 8'hFF, 1'b1};
        vecs[9]  = '{10'b11_0000_0000, 8'h00, 8'hFF, 1'b0};
        vecs[10] = '{10'b10_0000_0000, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{10'b11_0000_0000, 8'h00, 8'hA5, 1'b0};
        vecs[12] = '{10'b10_0010_0000, 8'h00, 8'h20, 1'b1};
        vecs[13] = '{10'b11_0000_0000, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{10'b00_0011_1100, 8'h00, 8'h3C, 1'b0};

        // Reset held for 2 cycles
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks("reset");

        // Table-driven frames
        for (int i = 0; i < 15; i++) begin
            fr = vecs[i].frame;
            if (fr[9:8] == CMD_RD_DATA) begin
                fr[7:0] = 8'($urandom);
                sb_q.push_back(vecs[i].val);
            end
            run_frame(fr);
            case (fr[9:8])
                CMD_WR_ADDR: chk($sformatf("vec%0d_wr_addr", i), dut.ram_inst.wr_addr, vecs[i].val);
                CMD_WR_DATA: chk($sformatf("vec%0d_mem", i), dut.ram_inst.mem[vecs[i].addr], vecs[i].val);
                CMD_RD_ADDR: chk($sformatf("vec%0d_rd_addr", i), dut.ram_inst.rd_addr, vecs[i].val);
                default:     ;
            endcase
            chk($sformatf("vec%0d_rd_addr_done", i), dut.spi_slave_inst.rd_addr_Done, vecs[i].done);
        end

        // Abort a write-address frame after 5 bits
        abort_frame(10'b00_1111_1111, 5, WRITE, rxv);
        chk("abort_wr_addr_kept", dut.ram_inst.wr_addr, 8'h3C);
        chk("abort_no_rx_valid", rxv, 0);

        // Abort a read-data frame: rd_addr_Done must survive
        run_frame(10'b10_0111_0011);
        chk("rd_addr_done_set", dut.spi_slave_inst.rd_addr_Done, 1);
        abort_frame(10'b11_0101_0101, 4, READ_DATA, rxv);
        chk("abort_rd_done_kept", dut.spi_slave_inst.rd_addr_Done, 1);
        chk("abort_rd_no_tx_valid", dut.ram_inst.tx_valid, 0);
        chk("abort_rd_no_rx_valid", rxv, 0);
        sb_q.push_back(8'h0D);
        run_frame(10'b11_1100_0011);
        chk("reread_rd_done_clear", dut.spi_slave_inst.rd_addr_Done, 0);

        // Reset asserted mid-frame
        fr = 10'b01_0101_0101;
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 9; i >= 4; i--) begin
            @(negedge clk);
            MOSI = fr[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs", dut.spi_slave_inst.cs, IDLE);
        chk("async_rst_mem73", dut.ram_inst.mem[8'h73], 0);
        chk("async_rst_wr_addr", dut.ram_inst.wr_addr, 0);
        repeat (2) @(negedge clk);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks("midreset");

        // Recovery after reset
        run_frame(10'b00_0100_0010);
        chk("recover_wr_addr", dut.ram_inst.wr_addr, 8'h42);
        run_frame(10'b01_1001_1001);
        chk("recover_mem42", dut.ram_inst.mem[8'h42], 8'h99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_wrapper.md
SPI_WRAPPER -- requirements
Module: spi_wrapper

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of RAM words.
REQ-002 Parameter DATA_ADDR_SIZE, default 8: width of address and data words.
REQ-003 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port SS_n, input, 1: slave select, active-low; a high level frames transactions.
REQ-006 Port MOSI, input, 1: serial data in, MSB first, sampled on the rising clk edge.
REQ-007 Port MISO, output, 1: serial data out, MSB first; 0 when not transmitting.

Function
REQ-008 Each frame SHALL be 10 bits: cmd[9:8] followed by payload[7:0]; cmd 00 = write address, 01 = write data, 10 = read address, 11 = read data.
REQ-009 Slave FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-010 IDLE SHALL go to CHK_CMD on the first edge with SS_n=0.
REQ-011 In CHK_CMD, the MOSI bit (frame bit 9) SHALL be shifted in, and the next state SHALL be chosen as follows.
REQ-011a If that bit is 0, the next state SHALL be WRITE.
REQ-011b If that bit is 1 and the internal flag rd_addr_Done=0, the next state SHALL be READ_ADD.
REQ-011c If that bit is 1 and rd_addr_Done=1, the next state SHALL be READ_DATA.
REQ-012 In WRITE, READ_ADD and READ_DATA, the slave SHALL shift in the remaining 9 bits, one per clk, counted by a bit counter.
REQ-013 One cycle after the 10th bit, rx_data[9:0] SHALL hold the frame and rx_valid SHALL pulse high for exactly one cycle.
REQ-014 The RAM SHALL act only on edges where rx_valid=1, decoding rx_data[9:8] as follows.
REQ-014a On 00: wr_addr <= rx_data[7:0].
REQ-014b On 01: mem[wr_addr] <= rx_data[7:0].
REQ-014c On 10: rd_addr <= rx_data[7:0].
REQ-014d On 11: dout <= mem[rd_addr] and tx_valid <= 1.
REQ-015 tx_valid SHALL fall when the next non-11 frame is received or on SS_n=1.
REQ-016 rd_addr_Done SHALL set when a READ_ADD frame completes and SHALL clear when a READ_DATA transmission completes.
REQ-017 In READ_DATA, on the first tx_valid=1, the slave SHALL load tx_data <= dout.
REQ-018 From the following cycle, the slave SHALL drive MISO with tx_data MSB first for exactly 8 cycles, then drive 0 and stay in READ_DATA until SS_n=1.
REQ-019 The MISO timeline SHALL be: 10th bit sampled at edge N; rx_valid high after edge N+1; tx_valid high after edge N+2; MISO bit7..bit0 valid after edges N+3..N+10.
REQ-020 SS_n=1 in any state SHALL return the FSM to IDLE on the next edge, clearing the bit counter, rx_valid and MISO, and aborting the frame with no RAM update.
REQ-021 An aborted frame SHALL leave rd_addr_Done unchanged.
REQ-022 Addresses SHALL be DATA_ADDR_SIZE bits and index mem directly; no wrap logic is needed for the default MEM_DEPTH=256.

Reset
REQ-023 On rst_n=0, the following SHALL be cleared asynchronously: FSM state to IDLE, bit counter, rx_data, rx_valid, tx_data, rd_addr_Done, MISO, wr_addr, rd_addr, dout and tx_valid (all 0).
REQ-024 Reset SHALL clear every mem word to 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA) and the command codes (00, 01, 10, 11).
REQ-027 spi_wrapper SHALL instantiate two sub-modules with these instance names, which benches probe hierarchically:
REQ-027a spi_slave (instance spi_slave_inst), exposing cs, ns, bit_count, rx_data, rx_valid, tx_data and rd_addr_Done.
REQ-027b sp_sync_ram (instance ram_inst), exposing mem, din, wr_addr, rd_addr, dout and tx_valid.

Verification
REQ-028 Reset: hold rst_n=0 for 2 cycles -> all of mem = 0, and dout, tx_valid, wr_addr, rd_addr, rx_data, rx_valid, MISO = 0.
REQ-029 Write address: SS_n=0, then frame 00_0111_0011, then SS_n=1 -> wr_addr = 0x73.
REQ-030 Write data: frame 01_0000_1101 -> mem[0x73] = 0x0D.
REQ-031 Read address: frame 10_0111_0011 -> rd_addr = 0x73 and rd_addr_Done = 1.
REQ-032 Read data: frame 11 + 8 random bits, SS_n held low for 13 more cycles -> tx_valid pulses, MISO serializes 0,0,0,0,1,1,0,1, and rd_addr_Done returns to 0.
REQ-033 Abort: raise SS_n after 5 bits of frame 00_1111_1111 -> state IDLE next cycle, wr_addr unchanged, no rx_valid pulse.
